// File: rtl/clock_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : clock_div_ctrl
// Description : Rollover-counter clock divider sequencer. It counts 0..D,
//               emits a one-cycle rollover pulse on each wrap, and toggles a
//               derived clock on each wrap. Divisor updates arrive over a
//               valid/ready handshake and are applied only on rollover
//               boundaries. Start and stop are glitch-free: the derived clock
//               always stops low and never has a truncated high phase.
// Ports       : clk          - system clock (rising edge)
//               reset        - asynchronous active-high reset
//               i_start      - start/resume request (level)
//               i_stop       - stop request (level, wins over start in RUN)
//               i_div_valid  - new divisor offered
//               i_div        - divisor value D (rollover every D+1 cycles)
//               o_div_ready  - divisor can be accepted this cycle
//               o_roll_over  - registered one-cycle wrap pulse
//               o_clk        - registered derived clock
//               o_running    - high in RUN and STOPPING
//               o_count      - current counter value
// Revision    : 1.0 - initial release
// ============================================================================
module clock_div_ctrl #(
  parameter int WIDTH       = 8,
  parameter int DEFAULT_DIV = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_start,
  input  logic             i_stop,
  input  logic             i_div_valid,
  input  logic [WIDTH-1:0] i_div,
  output logic             o_div_ready,
  output logic             o_roll_over,
  output logic             o_clk,
  output logic             o_running,
  output logic [WIDTH-1:0] o_count
);

  localparam logic [WIDTH-1:0] DEFAULT_DIV_W = WIDTH'(DEFAULT_DIV);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_RUN      = 2'd1,
    ST_STOPPING = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic             clk_q, clk_d;
  logic             roll_q, roll_d;
  logic [WIDTH-1:0] div_active_q, div_active_d;
  logic             pend_valid_q, pend_valid_d;
  logic [WIDTH-1:0] pend_div_q, pend_div_d;

  logic w_wrap;
  logic w_accept;

  assign w_wrap   = (count_q == div_active_q);
  assign w_accept = i_div_valid & ~pend_valid_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      clk_q        <= 1'b0;
      roll_q       <= 1'b0;
      div_active_q <= DEFAULT_DIV_W;
      pend_valid_q <= 1'b0;
      pend_div_q   <= '0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      clk_q        <= clk_d;
      roll_q       <= roll_d;
      div_active_q <= div_active_d;
      pend_valid_q <= pend_valid_d;
      pend_div_q   <= pend_div_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    clk_d        = clk_q;
    roll_d       = 1'b0;
    div_active_d = div_active_q;
    pend_valid_d = pend_valid_q;
    pend_div_d   = pend_div_q;

    case (state_q)
      ST_IDLE: begin
        count_d = '0;
        clk_d   = 1'b0;
        // No counting in IDLE, so a new divisor can be taken directly.
        if (w_accept) div_active_d = i_div;
        if (i_start)  state_d = ST_RUN;
      end

      ST_RUN, ST_STOPPING: begin
        // Common counting behaviour shared by RUN and STOPPING.
        if (w_wrap) begin
          count_d = '0;
          roll_d  = 1'b1;
          clk_d   = ~clk_q;
          if (pend_valid_q) begin
            div_active_d = pend_div_q;
            pend_valid_d = 1'b0;
          end
          // Transfer on the wrap edge itself bypasses the pending slot.
          if (w_accept) div_active_d = i_div;
        end else begin
          count_d = count_q + WIDTH'(1);
          if (w_accept) begin
            pend_valid_d = 1'b1;
            pend_div_d   = i_div;
          end
        end

        if (state_q == ST_RUN) begin
          if (i_stop) begin
            if (!clk_q) begin
              // Derived clock already low: stop immediately with no pulse.
              // Any divisor in flight is committed since the count is
              // returning to zero, otherwise it would be stranded in IDLE.
              state_d      = ST_IDLE;
              count_d      = '0;
              roll_d       = 1'b0;
              clk_d        = 1'b0;
              pend_valid_d = 1'b0;
              if (w_accept)          div_active_d = i_div;
              else if (pend_valid_q) div_active_d = pend_div_q;
            end else if (w_wrap) begin
              // This wrap is itself the terminal 1->0 edge.
              state_d = ST_IDLE;
            end else begin
              state_d = ST_STOPPING;
            end
          end
        end else begin
          // In STOPPING the derived clock is always high, so a wrap here
          // is the falling edge that ends generation.
          if (i_start && !i_stop) state_d = ST_RUN;
          else if (w_wrap)        state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign o_div_ready = ~pend_valid_q;
  assign o_roll_over = roll_q;
  assign o_clk       = clk_q;
  assign o_running   = (state_q != ST_IDLE);
  assign o_count     = count_q;

endmodule
`default_nettype wire

// File: tb/tb_clock_div_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_clock_div_ctrl
// Description : Directed self-checking bench for clock_div_ctrl. Outputs are
//               sampled 1 time unit after each rising edge and compared as
//               {o_running, o_clk, o_roll_over, o_count} against hand-computed
//               values; o_div_ready is compared separately where it matters.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_clock_div_ctrl;

  logic       clk;
  logic       reset;
  logic       i_start;
  logic       i_stop;
  logic       i_div_valid;
  logic [7:0] i_div;
  logic       o_div_ready;
  logic       o_roll_over;
  logic       o_clk;
  logic       o_running;
  logic [7:0] o_count;

  int checks;
  int errors;

  clock_div_ctrl #(.WIDTH(8), .DEFAULT_DIV(3)) dut (
    .clk         (clk),
    .reset       (reset),
    .i_start     (i_start),
    .i_stop      (i_stop),
    .i_div_valid (i_div_valid),
    .i_div       (i_div),
    .o_div_ready (o_div_ready),
    .o_roll_over (o_roll_over),
    .o_clk       (o_clk),
    .o_running   (o_running),
    .o_count     (o_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] obs;
    reset = 1'b1;
    repeat (3) tick();
    obs = {o_running, o_clk, o_roll_over, o_count};
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp %b", obs, 11'b0);
    end
    checks++;
    if (o_div_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_ready got %b exp 1", o_div_ready);
    end
    reset = 1'b0;
  endtask

  // Start from IDLE with D=3, check 16 cycles of the waveform.
  task automatic test_default_run(input string tag);
    logic [10:0] obs, exp;
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    obs = {o_running, o_clk, o_roll_over, o_count};
    exp = {1'b1, 1'b0, 1'b0, 8'd0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s start got %b exp %b", tag, obs, exp);
    end
    for (int i = 1; i <= 16; i++) begin
      tick();
      obs = {o_running, o_clk, o_roll_over, o_count};
      exp = {1'b1, 1'(((i / 4) % 2)), 1'(i % 4 == 0), 8'(i % 4)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL %s cycle %0d got %b exp %b", tag, i, obs, exp);
      end
    end
  endtask

  // Entry: count=0, clk=0, D=3. Exit: count=0, clk=0, D=3.
  task automatic test_reconfig();
    logic [10:0] obs, exp;
    tick();                       // count 1
    i_div_valid = 1'b1;
    i_div       = 8'd1;
    tick();                       // count 2, value parked in pending
    i_div_valid = 1'b0;
    checks++;
    if (o_div_ready !== 1'b0 || o_count !== 8'd2) begin
      errors++;
      $display("FAIL reconfig_pending got rdy=%b cnt=%0d exp rdy=0 cnt=2", o_div_ready, o_count);
    end
    tick();                       // count 3
    checks++;
    if (o_div_ready !== 1'b0 || o_count !== 8'd3) begin
      errors++;
      $display("FAIL reconfig_hold got rdy=%b cnt=%0d exp rdy=0 cnt=3", o_div_ready, o_count);
    end
    tick();                       // rollover, D=1 takes effect
    obs = {o_running, o_clk, o_roll_over, o_count};
    exp = {1'b1, 1'b1, 1'b1, 8'd0};
    checks++;
    if (obs !== exp || o_div_ready !== 1'b1) begin
      errors++;
      $display("FAIL reconfig_apply got %b rdy=%b exp %b rdy=1", obs, o_div_ready, exp);
    end
    for (int j = 1; j <= 8; j++) begin
      tick();
      obs = {o_running, o_clk, o_roll_over, o_count};
      exp = {1'b1, 1'(1 ^ ((j / 2) % 2)), 1'(j % 2 == 0), 8'(j % 2)};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL reconfig_d1 cycle %0d got %b exp %b", j, obs, exp);
      end
    end
    // Now count=0, clk=1, D=1. Restore D=3 through the pending path.
    i_div_valid = 1'b1;
    i_div       = 8'd3;
    tick();                       // count 1, pending
    i_div_valid = 1'b0;
    tick();                       // wrap: clk 0, D=3
    obs = {o_running, o_clk, o_roll_over, o_count};
    exp = {1'b1, 1'b0, 1'b1, 8'd0};
    checks++;
    if (obs !== exp || o_div_ready !== 1'b1) begin
      errors++;
      $display("FAIL reconfig_restore got %b rdy=%b exp %b rdy=1", obs, o_div_ready, exp);
    end
  endtask

  // Entry: count=0, clk=0, D=3, RUN. Exit: IDLE.
  task automatic test_stop_high();
    logic [10:0] obs, exp;
    repeat (4) tick();            // c1, c2, c3, wrap -> clk 1
    tick();                       // c1, clk 1
    i_stop = 1'b1;
    tick();
    obs = {o_running, o_clk, o_roll_over, o_count};
    exp = {1'b1, 1'b1, 1'b0, 8'd2};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL stop_high_s1 got %b exp %b", obs, exp);
    end
    tick();
    exp = {1'b1, 1'b1, 1'b0, 8'd3};
    obs = {o_running, o_clk, o_roll_over, o_count};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL stop_high_s2 got %b exp %b", obs, exp);
    end
    tick();                       // terminal rollover
    exp = {1'b0, 1'b0, 1'b1, 8'd0};
    obs = {o_running, o_clk, o_roll_over, o_count};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL stop_high_end got %b exp %b", obs, exp);
    end
    for (int k = 0; k < 6; k++) begin
      tick();
      obs = {o_running, o_clk, o_roll_over, o_count};
      checks++;
      if (obs !== 11'b0) begin
        errors++;
        $display("FAIL stop_high_idle %0d got %b exp %b", k, obs, 11'b0);
      end
    end
    i_stop = 1'b0;
  endtask

  // Entry: IDLE, D=3. Exit: IDLE.
  task automatic test_stop_low_and_cancel();
    logic [10:0] obs, exp;
    i_start = 1'b1;
    tick();                       // RUN c0
    i_start = 1'b0;
    tick();                       // c1, clk 0
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
    obs = {o_running, o_clk, o_roll_over, o_count};
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL stop_low got %b exp %b", obs, 11'b0);
    end
    // Cancel during STOPPING.
    i_start = 1'b1;
    tick();                       // RUN c0
    i_start = 1'b0;
    repeat (4) tick();            // c1 c2 c3 wrap(clk 1)
    tick();                       // c1
    i_stop = 1'b1;
    tick();                       // STOPPING c2
    obs = {o_running, o_clk, o_roll_over, o_count};
    exp = {1'b1, 1'b1, 1'b0, 8'd2};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL cancel_stopping got %b exp %b", obs, exp);
    end
    i_stop  = 1'b0;
    i_start = 1'b1;
    tick();                       // RUN c3, undisturbed
    i_start = 1'b0;
    obs = {o_running, o_clk, o_roll_over, o_count};
    exp = {1'b1, 1'b1, 1'b0, 8'd3};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL cancel_resume got %b exp %b", obs, exp);
    end
    tick();                       // ordinary rollover, still running
    obs = {o_running, o_clk, o_roll_over, o_count};
    exp = {1'b1, 1'b0, 1'b1, 8'd0};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL cancel_roll got %b exp %b", obs, exp);
    end
    tick();                       // c1
    obs = {o_running, o_clk, o_roll_over, o_count};
    exp = {1'b1, 1'b0, 1'b0, 8'd1};
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL cancel_count got %b exp %b", obs, exp);
    end
    i_stop = 1'b1;
    tick();
    i_stop = 1'b0;
  endtask

  // Entry: IDLE. Exit: IDLE with D=0.
  task automatic test_div_zero();
    logic [10:0] obs, exp;
    i_div_valid = 1'b1;
    i_div       = 8'd0;
    tick();
    i_div_valid = 1'b0;
    checks++;
    if (o_div_ready !== 1'b1 || o_running !== 1'b0) begin
      errors++;
      $display("FAIL d0_load got rdy=%b run=%b exp rdy=1 run=0", o_div_ready, o_running);
    end
    i_start = 1'b1;
    tick();
    i_start = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      obs = {o_running, o_clk, o_roll_over, o_count};
      exp = {1'b1, 1'(k % 2), 1'b1, 8'd0};
      checks++;
      if (obs !== exp) begin
        errors++;
        $display("FAIL d0 cycle %0d got %b exp %b", k, obs, exp);
      end
    end
    i_stop = 1'b1;                // clk is 0 here
    tick();
    i_stop = 1'b0;
    obs = {o_running, o_clk, o_roll_over, o_count};
    checks++;
    if (obs !== 11'b0) begin
      errors++;
      $display("FAIL d0_stop got %b exp %b", obs, 11'b0);
    end
  endtask

  // Entry: IDLE with D=0.
  task automatic test_async_reset();
    logic [10:0] obs, exp;
    i_div_valid = 1'b1;
    i_div       = 8'd3;
    tick();
    i_div_valid = 1'b0;
    i_start = 1'b1;
    tick();                       // c0
    i_start = 1'b0;
    repeat (4) tick();            // c1 c2 c3 wrap(clk 1)
    tick();                       // c1
    i_div_valid = 1'b1;
    i_div       = 8'd5;
    tick();                       // c2, clk 1, pending 5
    i_div_valid = 1'b0;
    obs = {o_running, o_clk, o_roll_over, o_count};
    exp = {1'b1, 1'b1, 1'b0, 8'd2};
    checks++;
    if (obs !== exp || o_div_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_pre got %b rdy=%b exp %b rdy=0", obs, o_div_ready, exp);
    end
    #2;
    reset = 1'b1;
    #1;                           // well before the next rising edge
    obs = {o_running, o_clk, o_roll_over, o_count};
    checks++;
    if (obs !== 11'b0 || o_div_ready !== 1'b1) begin
      errors++;
      $display("FAIL areset_async got %b rdy=%b exp %b rdy=1", obs, o_div_ready, 11'b0);
    end
    repeat (2) tick();
    reset = 1'b0;
    test_default_run("restart");
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    i_start     = 1'b0;
    i_stop      = 1'b0;
    i_div_valid = 1'b0;
    i_div       = 8'd0;
    #2;
    test_reset();
    test_default_run("default");
    test_reconfig();
    test_stop_high();
    test_stop_low_and_cancel();
    test_div_zero();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
